latch_capture_scheduler: RTL and testbench
==========================================

Name: latch_capture_scheduler

Overview:
- Arbitrates four requesters for the shared 4-bit capture latch and the per-bit output register bank behind it.
- Sequences each transfer in a fixed order: open latch (capture), hold it closed while data settles, then strobe the commit that samples it into the output registers.
- Sits in top, upstream of the capture latch: drives its enable and data, and drives the commit strobe toward the per-bit register modules.

Parameters:
- NREQ, 4, number of requesters (one-hot grant width).
- WIDTH, 4, data width per requester and of the capture path.
- SETTLE_CYCLES, 1, cycles the latch is held closed between capture and commit; legal range 0..15.

Ports:
- i_clk  input  1  clock, all state updates on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_en  input  1  global arbitration enable; low blocks new grants only.
- i_req  input  NREQ  per-requester request level.
- i_a  input  NREQ*WIDTH  requester data; requester r occupies bits [r*WIDTH +: WIDTH].
- o_gnt  output  NREQ  one-hot grant, one-cycle pulse.
- o_en  output  1  capture-latch enable (latch transparent while high).
- o_a  output  WIDTH  data presented to the latch D inputs.
- o_commit  output  1  one-cycle strobe; downstream registers sample the latch.
- o_busy  output  1  high whenever state is not IDLE.

Behaviour:
- All outputs are registered. Reset (asynchronous assert, synchronous release) forces: state IDLE; o_gnt=0; o_en=0; o_a=0; o_commit=0; o_busy=0; round-robin pointer=0; settle counter=0.
- States are IDLE, CAPTURE, SETTLE and COMMIT.
- IDLE: if i_en=1 and |i_req, pick the winner at the clock edge, then go to CAPTURE.
- CAPTURE lasts exactly 1 cycle. During it: o_gnt=onehot(winner), o_en=1, o_a=winner's data slice, o_busy=1.
- SETTLE lasts SETTLE_CYCLES cycles. o_en=0, o_a held, o_gnt=0. When SETTLE_CYCLES=0, SETTLE is skipped and CAPTURE goes directly to COMMIT.
- COMMIT lasts 1 cycle. o_commit=1, o_en=0, o_a held.
  - If i_en=1 and |i_req, go back-to-back into CAPTURE for the next winner.
  - Otherwise go to IDLE.
- Latency: a request sampled in IDLE at edge k gives CAPTURE in cycle k+1 and o_commit in cycle k+2+SETTLE_CYCLES.
- Back-to-back throughput is one transfer per 2+SETTLE_CYCLES cycles.
- o_a changes only on entry to CAPTURE. It is stable whenever o_en falls and throughout SETTLE and COMMIT.
- o_en and o_commit are never high in the same cycle. o_en is never high outside CAPTURE.
- Arbitration is round robin.
  - The search starts at the pointer and wraps modulo NREQ. The first set i_req bit wins.
  - On grant, pointer = (winner+1) mod NREQ.
  - A requester still requesting after its commit therefore drops to lowest priority.
- Handshake rules:
  - Data is captured from i_a only in the cycle the grant is decided. The requester must hold its slice valid while requesting.
  - The requester must deassert i_req or present new data in the cycle after seeing o_gnt. A held i_req is treated as a new request.
- Request withdrawal and i_en changes after the grant do not affect the in-flight transfer. i_en low only blocks the IDLE→CAPTURE and COMMIT→CAPTURE decisions.
- Reset asserted mid-transfer aborts the transfer immediately: o_en and o_commit drop asynchronously and no commit is issued. After release, arbitration restarts from pointer 0.
- The settle counter loads SETTLE_CYCLES-1 on entry to SETTLE and decrements to 0. Its width is sized for the maximum of 15.

Test Plan:
- Reset then single request: i_rst_n released, i_en=1, i_req=0100, slice2=4'hA, SETTLE_CYCLES=1.
  - Next cycle: o_gnt=0100, o_en=1, o_a=4'hA.
  - Then 1 cycle with o_en=0.
  - Then o_commit=1 with o_a=4'hA.
  - Then o_busy=0.
- Round robin: i_req=1111 held, slices 1,2,3,4.
  - Grant order 0001, 0010, 0100, 1000, 0001.
  - o_a sequence 1,2,3,4,1.
  - CAPTURE entries spaced 3 cycles apart.
- SETTLE_CYCLES=0 variant: i_req=0001 held.
  - o_en and o_commit alternate every cycle.
  - They never overlap.
- i_en gating: i_en=0 with i_req=0010 → o_gnt stays 0 and o_busy=0 indefinitely. Raising i_en grants 0010 on the next edge.
- Mid-transfer reset: i_rst_n pulsed low during SETTLE.
  - Outputs go to 0 immediately and no o_commit pulse occurs.
  - With i_req=1000 after release, the next grant is 1000 (search from pointer 0).
- Data stability: change i_a every cycle during SETTLE and COMMIT → o_a holds the value captured at grant.

Source files
------------

// File: rtl/latch_capture_scheduler_if.sv
// Requester-side bus of the capture-latch scheduler: request/data inputs
// from the four requesters plus the grant, latch and commit outputs.
interface latch_capture_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  logic                    i_en;
  logic [NREQ-1:0]         i_req;
  logic [NREQ*WIDTH-1:0]   i_a;
  logic [NREQ-1:0]         o_gnt;
  logic                    o_en;
  logic [WIDTH-1:0]        o_a;
  logic                    o_commit;
  logic                    o_busy;

  // Requesters / environment drive the request side.
  modport master (
    output i_en, i_req, i_a,
    input  o_gnt, o_en, o_a, o_commit, o_busy
  );

  // The scheduler consumes requests and drives the latch controls.
  modport slave (
    input  i_en, i_req, i_a,
    output o_gnt, o_en, o_a, o_commit, o_busy
  );
endinterface

// File: rtl/latch_capture_scheduler.sv
// Round-robin scheduler for a shared capture latch. Each transfer runs
// CAPTURE (latch open) -> SETTLE (latch closed, SETTLE_CYCLES long) ->
// COMMIT (strobe downstream registers). All outputs are registered.
module latch_capture_scheduler #(
  parameter int NREQ          = 4,
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  latch_capture_scheduler_if.slave    bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] CNT_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, CAPTURE, SETTLE, COMMIT} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [3:0]      settle_cnt;

  logic            win_valid;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   win_next;
  logic [PW-1:0]   cand;
  logic [NREQ-1:0] win_gnt;
  logic [WIDTH-1:0] win_data;

  // Round-robin winner search starting at ptr; the descending loop lets the
  // earliest candidate in search order overwrite later ones.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (bus.i_req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Winner's one-hot grant, data slice and the pointer value after it.
  always_comb begin
    win_data = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (win_idx == PW'(r)) win_data = bus.i_a[r*WIDTH +: WIDTH];
    end
    win_gnt  = NREQ'(1) << win_idx;
    win_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  end

  // Transfer sequencer with registered outputs; reset aborts any transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      settle_cnt   <= '0;
      bus.o_gnt    <= '0;
      bus.o_en     <= 1'b0;
      bus.o_a      <= '0;
      bus.o_commit <= 1'b0;
      bus.o_busy   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      bus.o_gnt    <= '0;
      bus.o_en     <= 1'b0;
      bus.o_commit <= 1'b0;
      case (state)
        IDLE, COMMIT: begin
          if (bus.i_en && win_valid) begin
            state      <= CAPTURE;
            bus.o_gnt  <= win_gnt;
            bus.o_en   <= 1'b1;
            bus.o_a    <= win_data;
            bus.o_busy <= 1'b1;
            ptr        <= win_next;
          end else begin
            state      <= IDLE;
            bus.o_busy <= 1'b0;
          end
        end
        CAPTURE: begin
          if (SETTLE_CYCLES == 0) begin
            state        <= COMMIT;
            bus.o_commit <= 1'b1;
          end else begin
            state      <= SETTLE;
            settle_cnt <= CNT_LOAD;
          end
        end
        SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state        <= COMMIT;
            bus.o_commit <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_capture_scheduler.sv
// Scoreboard bench: two scheduler instances (SETTLE_CYCLES = 1 and 0) share
// one stimulus stream. A transfer-level model predicts each grant/commit and
// queues it; per-lane monitors pop and compare when the DUT presents them.
module tb_latch_capture_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  typedef struct {
    int                cyc;
    logic [NREQ-1:0]   gnt;
    logic [WIDTH-1:0]  data;
  } xfer_t;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  en    = 1'b0;
  logic [NREQ-1:0]       req   = '0;
  logic [NREQ*WIDTH-1:0] a     = '0;
  bit                    done  = 1'b0;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  // Edge counter used to time-stamp expected events.
  initial forever begin
    @(posedge clk);
    edge_n = edge_n + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int S = (g == 0) ? 1 : 0;

    latch_capture_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
    assign bus.i_en  = en;
    assign bus.i_req = req;
    assign bus.i_a   = a;

    latch_capture_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE_CYCLES(S)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
    );

    xfer_t            cap_q[$];
    xfer_t            com_q[$];
    int               ptr;
    int               next_decide;
    bit               busy_exp;
    bit               en_exp;
    logic [WIDTH-1:0] held;

    // Transfer-level model: a decision may happen at an edge only when no
    // transfer is outstanding; a grant occupies 2+S cycles from that edge.
    initial begin
      ptr = 0; next_decide = 0; busy_exp = 0; en_exp = 0; held = '0;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          ptr = 0; next_decide = 0; busy_exp = 0; en_exp = 0;
          cap_q.delete();
          com_q.delete();
        end else begin
          int w;
          xfer_t x;
          w = -1;
          en_exp = 0;
          if (edge_n >= next_decide) begin
            if (en) begin
              for (int k = 0; k < NREQ; k++)
                if (w < 0 && req[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
            end
            if (w >= 0) begin
              x.gnt  = NREQ'(1) << w;
              x.data = a[w*WIDTH +: WIDTH];
              x.cyc  = edge_n;
              cap_q.push_back(x);
              x.cyc  = edge_n + 1 + S;
              com_q.push_back(x);
              ptr         = (w + 1) % NREQ;
              next_decide = edge_n + 2 + S;
              busy_exp    = 1;
              en_exp      = 1;
              held        = x.data;
            end else begin
              busy_exp    = 0;
              next_decide = edge_n + 1;
            end
          end
        end
      end
    end

    // Monitor: samples on the falling edge, pops expected captures/commits.
    initial forever begin
      xfer_t x;
      @(negedge clk);
      if (!rst_n) begin
        check($sformatf("L%0d reset gnt", g),    32'(bus.o_gnt),    0);
        check($sformatf("L%0d reset en", g),     32'(bus.o_en),     0);
        check($sformatf("L%0d reset a", g),      32'(bus.o_a),      0);
        check($sformatf("L%0d reset commit", g), 32'(bus.o_commit), 0);
        check($sformatf("L%0d reset busy", g),   32'(bus.o_busy),   0);
      end else begin
        check($sformatf("L%0d busy", g), 32'(bus.o_busy), 32'(busy_exp));
        check($sformatf("L%0d en", g),   32'(bus.o_en),   32'(en_exp));
        check($sformatf("L%0d en_commit_overlap", g), 32'(bus.o_en & bus.o_commit), 0);
        while (cap_q.size() > 0 && cap_q[0].cyc < edge_n) begin
          check($sformatf("L%0d missed capture cycle", g), edge_n, cap_q[0].cyc);
          void'(cap_q.pop_front());
        end
        while (com_q.size() > 0 && com_q[0].cyc < edge_n) begin
          check($sformatf("L%0d missed commit cycle", g), edge_n, com_q[0].cyc);
          void'(com_q.pop_front());
        end
        if (bus.o_gnt != '0 || bus.o_en) begin
          if (cap_q.size() == 0) begin
            check($sformatf("L%0d unexpected capture", g), 32'({bus.o_en, bus.o_gnt}), 0);
          end else begin
            x = cap_q.pop_front();
            check($sformatf("L%0d capture gnt", g),   32'(bus.o_gnt), 32'(x.gnt));
            check($sformatf("L%0d capture a", g),     32'(bus.o_a),   32'(x.data));
            check($sformatf("L%0d capture cycle", g), edge_n,         x.cyc);
          end
        end
        if (bus.o_commit) begin
          if (com_q.size() == 0) begin
            check($sformatf("L%0d unexpected commit", g), 32'(bus.o_commit), 0);
          end else begin
            x = com_q.pop_front();
            check($sformatf("L%0d commit a", g),     32'(bus.o_a), 32'(x.data));
            check($sformatf("L%0d commit cycle", g), edge_n,       x.cyc);
          end
        end
        if (busy_exp && !en_exp)
          check($sformatf("L%0d a hold", g), 32'(bus.o_a), 32'(held));
      end
    end

    // Outputs must clear as soon as reset asserts, without waiting for a clock.
    initial forever begin
      @(negedge rst_n);
      #1;
      check($sformatf("L%0d async rst en", g),     32'(bus.o_en),     0);
      check($sformatf("L%0d async rst commit", g), 32'(bus.o_commit), 0);
      check($sformatf("L%0d async rst gnt", g),    32'(bus.o_gnt),    0);
      check($sformatf("L%0d async rst busy", g),   32'(bus.o_busy),   0);
    end

    // Nothing may remain outstanding once stimulus has drained.
    initial begin
      wait (done);
      check($sformatf("L%0d capture queue drained", g), cap_q.size(), 0);
      check($sformatf("L%0d commit queue drained", g),  com_q.size(), 0);
    end
  end

  task automatic drive(input bit e, input logic [NREQ-1:0] r,
                       input logic [NREQ*WIDTH-1:0] d, input int n);
    en = e; req = r; a = d;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Single request from requester 2 with data A.
    drive(1, 4'b0100, 16'h0A00, 1);
    drive(1, 4'b0000, 16'h0A00, 6);

    // Round robin from pointer 0 with all requesters active.
    reset_pulse();
    drive(1, 4'b1111, 16'h4321, 16);
    drive(1, 4'b0000, 16'h4321, 4);

    // Single requester held: back-to-back transfers, alternating en/commit at S=0.
    drive(1, 4'b0001, 16'h0005, 8);
    drive(1, 4'b0000, 16'h0005, 4);

    // Data stability: i_a changes every cycle after the grant.
    drive(1, 4'b0001, 16'h000A, 1);
    for (int i = 0; i < 4; i++) drive(1, 4'b0000, 16'($urandom), 1);
    drive(1, 4'b0000, 16'h0000, 3);

    // Enable gating: requests ignored while i_en is low.
    drive(0, 4'b0010, 16'h00B0, 10);
    drive(1, 4'b0010, 16'h00B0, 1);
    drive(1, 4'b0000, 16'h00B0, 5);

    // Reset during SETTLE aborts the transfer; arbitration restarts at 0.
    drive(1, 4'b1000, 16'hC000, 1);
    drive(1, 4'b0000, 16'hC000, 3);
    drive(1, 4'b0001, 16'h0007, 1);
    drive(1, 4'b0000, 16'h0007, 1);
    reset_pulse();
    drive(1, 4'b1000, 16'hD000, 1);
    drive(1, 4'b0000, 16'hD000, 5);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 7) != 0), NREQ'($urandom), 16'($urandom), 1);

    drive(0, 4'b0000, 16'h0000, 8);
    done = 1'b1;
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
